ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes RS1data, RS2data, funct and RDaddr as held in ID/EX.
- Executes RV32M ops in 1 bit per cycle and asserts busy_o so the hazard logic freezes PC, IF/ID and ID/EX and bubbles EX/MEM until the result is ready.
- Result is muxed into the EX result path alongside the ALU output.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 6, iteration counter width; must hold XLEN

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  EX holds a valid M-extension instruction (from ID/EX)
- flush_i  in  1  kill in-flight op (branch/exception flush)
- funct_i  in  10  {funct7, funct3}; M-op only when funct7 = 7'b0000001
- RS1data_i  in  XLEN  operand A (post-forwarding)
- RS2data_i  in  XLEN  operand B (post-forwarding)
- RDaddr_i  in  5  destination register
- busy_o  out  1  stall request to hazard unit
- done_o  out  1  one-cycle result-valid strobe
- result_o  out  XLEN  result; valid when done_o=1
- RDaddr_o  out  5  destination of result, valid with done_o

Behaviour:
- Clock/reset: single clock clk_i; rst_i synchronous, active-high.
- Reset:
  - state=IDLE, counter=0, done_o=0, result_o=0, RDaddr_o=0.
  - busy_o=0 on the cycle after reset.
  - Reset mid-RUN aborts with no done_o.
- Accept: in IDLE with start_i=1 and funct7=0000001:
  - latch funct3, RDaddr, operand magnitudes and sign-fix flags.
  - If funct7 differs, ignore start_i; busy_o stays 0.
- busy_o = (IDLE & accept) | RUN. Combinational, so the stall applies in the accept cycle itself.
- States:
  - IDLE -> RUN on accept.
  - IDLE -> DONE on accept when a shortcut case applies.
  - RUN -> DONE when counter = XLEN-1.
  - DONE -> IDLE unconditionally.
- Latency:
  - Accept at cycle T; RUN occupies T+1..T+32; DONE at T+33.
  - In DONE: done_o=1, busy_o=0, result_o/RDaddr_o valid. The pipeline advances on that edge.
  - start_i is still high in DONE (same instruction) and is never re-accepted there. A new instruction can be accepted at T+34.
- Multiply (funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU):
  - Shift-add on magnitudes into a 2*XLEN product.
  - Signedness: MUL/MULH treat both operands signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
  - Negate product if the operand signs differ (signed operands only).
  - MUL returns low XLEN bits; the MULH variants return high XLEN bits.
- Divide (100 DIV, 101 DIVU, 110 REM, 111 REMU):
  - Restoring division on magnitudes.
  - Signed quotient is negated when the signs differ; signed remainder takes the dividend's sign.
- Shortcuts (IDLE -> DONE, done_o at T+1):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow, 0x80000000 / -1: quotient = 0x80000000; remainder = 0.
- flush_i:
  - Synchronous; forces IDLE next cycle, suppresses done_o, clears counter.
  - Priority: rst_i > flush_i > FSM. flush_i with start_i in IDLE does not accept.
- result_o/RDaddr_o hold their last value outside DONE. Consumers must qualify with done_o.

Decomposition:
- Shared package muldiv_pkg:
  - FUNCT7_MULDIV constant
  - funct3 op codes (OP_MUL..OP_REMU)
  - state enum {IDLE, RUN, DONE}
  - XLEN default
- Natural sub-module muldiv_iter_core: shift/add/subtract datapath plus counter, with load/step/last controls. The FSM, sign fix-up and shortcuts stay in ex_muldiv_unit.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), RD=5, accept at T -> busy_o high T..T+32; done_o at T+33 only; result_o=0xFFFFFFEB, RDaddr_o=5.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> done_o at T+1, result 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> done_o at T+1, result 0x80000000. REM of the same -> 0.
- flush_i at T+10 of a DIV -> IDLE at T+11, busy_o=0, no done_o. New MUL 3x4 accepted at T+11 -> done_o at T+44 with result 12.
- rst_i at T+5 mid-RUN -> all outputs 0 next cycle, no done_o. Back-to-back ops with start_i held through DONE -> exactly one done_o per instruction.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_pkg : shared constants, op codes and FSM states for the   |
// |              iterative RV32M multiply/divide unit                |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
package muldiv_pkg;

  localparam int         XLEN_DEF      = 32;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_iter_core : 1-bit-per-cycle shift-add / restoring-divide  |
// |                    datapath on unsigned magnitudes plus counter  |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  output logic             last,
  output logic [XLEN-1:0]  next_hi,
  output logic [XLEN-1:0]  next_lo
);

  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic             r_div;
  logic [CNT_W-1:0] r_cnt;

  logic [XLEN:0]    w_sum;
  logic [XLEN:0]    w_shifted;
  logic [XLEN:0]    w_diff;

  // Multiply: {hi,lo} shifts right while lo[0] gates the addend into hi.
  // Divide: {hi,lo} shifts left; hi holds the partial remainder, lo collects
  // quotient bits as the dividend drains out of its top.
  always_comb begin
    w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_shifted = {r_hi, r_lo[XLEN-1]};
    w_diff    = w_shifted - {1'b0, r_b};
    if (r_div) begin
      next_hi = w_diff[XLEN] ? w_shifted[XLEN-1:0] : w_diff[XLEN-1:0];
      next_lo = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
    end else begin
      next_hi = w_sum[XLEN:1];
      next_lo = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign last = (r_cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (load) begin
      r_hi  <= '0;
      r_lo  <= is_div ? op_a : op_b;
      r_a   <= op_a;
      r_b   <= op_b;
      r_div <= is_div;
      r_cnt <= '0;
    end else if (step) begin
      r_hi  <= next_hi;
      r_lo  <= next_lo;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_muldiv_unit : EX-stage iterative RV32M unit; FSM, sign fix-up, |
// |                  divide shortcuts and pipeline stall request      |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] RS1data_i,
  input  logic [XLEN-1:0] RS2data_i,
  input  logic [4:0]      RDaddr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      RDaddr_o
);

  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state, w_state_next;

  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic            r_neg_q;
  logic            r_neg_r;

  logic [2:0]      w_f3;
  logic            w_accept;
  logic            w_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div0;
  logic            w_ovf;
  logic            w_shortcut;
  logic [XLEN-1:0] w_sc_result;

  logic            w_last;
  logic [XLEN-1:0] w_next_hi;
  logic [XLEN-1:0] w_next_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_final;

  always_comb begin
    w_f3       = funct_i[2:0];
    w_accept   = (r_state == IDLE) && start_i && !flush_i &&
                 (funct_i[9:3] == FUNCT7_MULDIV);
    w_div      = w_f3[2];
    // Divides: bit0 clear means signed. Multiplies: only MULHU has unsigned A,
    // and only MUL/MULH have signed B.
    w_a_signed = w_div ? !w_f3[0] : (w_f3 != OP_MULHU);
    w_b_signed = w_div ? !w_f3[0] : !w_f3[1];
    w_neg_a    = w_a_signed && RS1data_i[XLEN-1];
    w_neg_b    = w_b_signed && RS2data_i[XLEN-1];
    w_mag_a    = w_neg_a ? (~RS1data_i + 1'b1) : RS1data_i;
    w_mag_b    = w_neg_b ? (~RS2data_i + 1'b1) : RS2data_i;
    w_div0     = w_div && (RS2data_i == '0);
    w_ovf      = w_div && !w_f3[0] && (RS1data_i == c_int_min) &&
                 (RS2data_i == '1);
    w_shortcut = w_div0 || w_ovf;
    if (w_div0)
      w_sc_result = w_f3[1] ? RS1data_i : '1;
    else
      w_sc_result = w_f3[1] ? '0 : c_int_min;
    busy_o     = w_accept || (r_state == RUN);
    done_o     = (r_state == DONE);
  end

  muldiv_iter_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (flush_i),
    .load    (w_accept && !w_shortcut),
    .step    (r_state == RUN),
    .is_div  (w_div),
    .op_a    (w_mag_a),
    .op_b    (w_mag_b),
    .last    (w_last),
    .next_hi (w_next_hi),
    .next_lo (w_next_lo)
  );

  // The last step's outputs feed the fix-up directly so result_o is ready in DONE.
  always_comb begin
    w_prod  = {w_next_hi, w_next_lo};
    if (r_neg_q)
      w_prod = ~w_prod + 1'b1;
    w_quo   = r_neg_q ? (~w_next_lo + 1'b1) : w_next_lo;
    w_rem   = r_neg_r ? (~w_next_hi + 1'b1) : w_next_hi;
    if (r_op[2])
      w_final = r_op[1] ? w_rem : w_quo;
    else
      w_final = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = w_shortcut ? DONE : RUN;
      RUN:  if (w_last)   w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (flush_i)
      w_state_next = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_o <= '0;
      RDaddr_o <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op    <= w_f3;
        r_rd    <= RDaddr_i;
        r_neg_q <= w_neg_a ^ w_neg_b;
        r_neg_r <= w_neg_a;
        if (w_shortcut) begin
          result_o <= w_sc_result;
          RDaddr_o <= RDaddr_i;
        end
      end else if ((r_state == RUN) && w_last && !flush_i) begin
        result_o <= w_final;
        RDaddr_o <= r_rd;
      end
    end
  end

endmodule
`default_nettype wire
